// File: rtl/sync_s2f_multi.sv
// sync_s2f_multi: multi-channel slow-to-fast level synchronizer.
// Each channel runs a STAGES-deep sync chain, a FILT_LEN stability filter,
// registered rise/fall detectors and a mode-selected event output.

module sync_s2f_lane #(
    parameter int STAGES   = 2,
    parameter int FILT_LEN = 1,
    parameter bit RST_VAL  = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dat,
    input  logic [1:0] mode,
    input  logic       clr,
    output logic       lvl,
    output logic       rise,
    output logic       fall,
    output logic       evt,
    output logic       glitch
);
    localparam int             CW       = $clog2(FILT_LEN) + 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(FILT_LEN - 1);

    logic [STAGES-1:0] sync_q;
    logic [CW-1:0]     cnt;
    logic              sq;
    logic              glitch_set;

    assign sq = sync_q[STAGES-1];
    // A pending change that reverts before acceptance counts as a glitch.
    assign glitch_set = (sq == lvl) && (cnt != '0);

    // Sync chain: only stage 0 touches the asynchronous input.
    always_ff @(posedge clk) begin
        if (rst) sync_q <= {STAGES{RST_VAL}};
        else     sync_q <= {sync_q[STAGES-2:0], dat};
    end

    // Stability filter, single-cycle edge pulses and sticky glitch flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            lvl    <= RST_VAL;
            cnt    <= '0;
            rise   <= 1'b0;
            fall   <= 1'b0;
            glitch <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (sq == lvl) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                lvl  <= sq;
                cnt  <= '0;
                rise <= sq;
                fall <= ~sq;
            end else begin
                cnt <= cnt + CW'(1);
            end
            // Set has priority over clear when both land in one cycle.
            if (glitch_set)  glitch <= 1'b1;
            else if (clr)    glitch <= 1'b0;
        end
    end

    // Mode select over registered level/pulses; mode is quasi-static.
    always_comb begin
        evt = 1'b0;
        case (mode)
            2'b00:   evt = lvl;
            2'b01:   evt = rise;
            2'b10:   evt = fall;
            default: evt = rise | fall;
        endcase
    end
endmodule

module sync_s2f_multi #(
    parameter int CH       = 4,
    parameter int STAGES   = 2,
    parameter int FILT_LEN = 1,
    parameter bit RST_VAL  = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CH-1:0]   dat_i,
    input  logic [2*CH-1:0] mode_i,
    input  logic            clr_i,
    output logic [CH-1:0]   lvl_o,
    output logic [CH-1:0]   rise_o,
    output logic [CH-1:0]   fall_o,
    output logic [CH-1:0]   evt_o,
    output logic [CH-1:0]   glitch_o
);
    // Channels are fully independent; one lane instance per channel.
    for (genvar c = 0; c < CH; c++) begin : g_lane
        sync_s2f_lane #(
            .STAGES   (STAGES),
            .FILT_LEN (FILT_LEN),
            .RST_VAL  (RST_VAL)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .dat    (dat_i[c]),
            .mode   (mode_i[2*c +: 2]),
            .clr    (clr_i),
            .lvl    (lvl_o[c]),
            .rise   (rise_o[c]),
            .fall   (fall_o[c]),
            .evt    (evt_o[c]),
            .glitch (glitch_o[c])
        );
    end
endmodule

// File: tb/tb_sync_s2f_multi.sv
// Bench for sync_s2f_multi: a window-based behavioural model checks every
// cycle of the main instance; directed scenarios add literal expectations,
// and a second instance covers the deeper-chain / reset-high configuration.

module tb_sync_s2f_multi;
    localparam int CH = 4;
    localparam int STG = 2;
    localparam int FL = 3;
    localparam bit RV = 1'b0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst = 1'b1;
    logic [CH-1:0]   dat_i = '0;
    logic [2*CH-1:0] mode_i = '0;
    logic            clr_i = 1'b0;
    logic [CH-1:0]   lvl_o, rise_o, fall_o, evt_o, glitch_o;

    logic       rst_b = 1'b1;
    logic [1:0] dat_b = 2'b11;
    logic [3:0] mode_b = '0;
    logic       clr_b = 1'b0;
    logic [1:0] lvl_b, rise_b, fall_b, evt_b, glitch_b;

    sync_s2f_multi #(.CH(CH), .STAGES(STG), .FILT_LEN(FL), .RST_VAL(RV)) dut (
        .clk(clk), .rst(rst), .dat_i(dat_i), .mode_i(mode_i), .clr_i(clr_i),
        .lvl_o(lvl_o), .rise_o(rise_o), .fall_o(fall_o), .evt_o(evt_o), .glitch_o(glitch_o)
    );

    sync_s2f_multi #(.CH(2), .STAGES(3), .FILT_LEN(1), .RST_VAL(1'b1)) dut_b (
        .clk(clk), .rst(rst_b), .dat_i(dat_b), .mode_i(mode_b), .clr_i(clr_b),
        .lvl_o(lvl_b), .rise_o(rise_b), .fall_o(fall_b), .evt_o(evt_b), .glitch_o(glitch_b)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    // Behavioural model: input delayed STAGES cycles, level accepted once the
    // last FILT_LEN synced samples since the previous decision all differ.
    bit dly [CH][$];
    bit hist [CH][$];
    bit [CH-1:0] m_lvl, m_rise, m_fall, m_glitch;
    bit model_on = 1'b0;

    always @(posedge clk) begin
        bit sq, all_diff, gset;
        int n;
        if (rst) begin
            for (int c = 0; c < CH; c++) begin
                dly[c].delete();
                for (int k = 0; k < STG; k++) dly[c].push_back(RV);
                hist[c].delete();
            end
            m_lvl = {CH{RV}};
            m_rise = '0;
            m_fall = '0;
            m_glitch = '0;
            model_on = 1'b1;
        end else begin
            for (int c = 0; c < CH; c++) begin
                sq = dly[c].pop_front();
                dly[c].push_back(dat_i[c]);
                hist[c].push_back(sq);
                if (hist[c].size() > FL + 1) void'(hist[c].pop_front());
                n = hist[c].size();
                all_diff = (n >= FL);
                for (int k = n - FL; k < n; k++)
                    if (k >= 0 && hist[c][k] == m_lvl[c]) all_diff = 1'b0;
                m_rise[c] = 1'b0;
                m_fall[c] = 1'b0;
                gset = 1'b0;
                if (all_diff) begin
                    m_rise[c] = sq;
                    m_fall[c] = !sq;
                    m_lvl[c] = sq;
                    hist[c].delete();
                end else if (sq == m_lvl[c] && n >= 2 && hist[c][n-2] != m_lvl[c]) begin
                    gset = 1'b1;
                end
                if (gset) m_glitch[c] = 1'b1;
                else if (clr_i) m_glitch[c] = 1'b0;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic [CH-1:0] m_evt;
        if (model_on) begin
            for (int c = 0; c < CH; c++) begin
                case (mode_i[2*c +: 2])
                    2'b00:   m_evt[c] = m_lvl[c];
                    2'b01:   m_evt[c] = m_rise[c];
                    2'b10:   m_evt[c] = m_fall[c];
                    default: m_evt[c] = m_rise[c] | m_fall[c];
                endcase
            end
            check("model_lvl", 32'(lvl_o), 32'(m_lvl));
            check("model_rise", 32'(rise_o), 32'(m_rise));
            check("model_fall", 32'(fall_o), 32'(m_fall));
            check("model_evt", 32'(evt_o), 32'(m_evt));
            check("model_glitch", 32'(glitch_o), 32'(m_glitch));
        end
    end

    // Pulse/event counters for the directed scenarios.
    bit cnt_en = 1'b0;
    int rise_cnt [CH];
    int fall_cnt [CH];
    int evt_cnt [CH];

    always @(negedge clk) begin
        if (cnt_en) begin
            for (int c = 0; c < CH; c++) begin
                rise_cnt[c] += int'(rise_o[c]);
                fall_cnt[c] += int'(fall_o[c]);
                evt_cnt[c]  += int'(evt_o[c]);
            end
        end
    end

    task automatic clear_counts();
        for (int c = 0; c < CH; c++) begin
            rise_cnt[c] = 0;
            fall_cnt[c] = 0;
            evt_cnt[c] = 0;
        end
    endtask

    logic [15:0] pat = 16'b0101001110101101;
    int hold [CH];

    initial begin
        // Reset with all inputs high: nothing leaves reset state.
        rst = 1'b1;
        dat_i = 4'hF;
        repeat (3) nxt();
        check("rst_lvl", 32'(lvl_o), 32'h0);
        check("rst_rise", 32'(rise_o), 32'h0);
        check("rst_fall", 32'(fall_o), 32'h0);
        check("rst_glitch", 32'(glitch_o), 32'h0);
        rst = 1'b0;
        // First sampling edge plus STAGES+FILT_LEN-1 = 4 further edges.
        repeat (4) begin
            nxt();
            check("rst_exit_lvl_hold", 32'(lvl_o), 32'h0);
        end
        nxt();
        check("rst_exit_lvl", 32'(lvl_o), 32'hF);
        check("rst_exit_rise", 32'(rise_o), 32'hF);
        nxt();
        check("rst_exit_rise_1cyc", 32'(rise_o), 32'h0);

        // Serial pattern on channel 0 driven at a 36ns pace, off the clock edges.
        dat_i = '0;
        repeat (10) nxt();
        clear_counts();
        cnt_en = 1'b1;
        @(negedge clk);
        #2;
        for (int i = 15; i >= 0; i--) begin
            dat_i[0] = pat[i];
            #36;
        end
        dat_i[0] = 1'b0;
        repeat (10) nxt();
        cnt_en = 1'b0;
        // The pattern has six runs of ones, closed by the trailing zero.
        check("serial_rise_cnt", 32'(rise_cnt[0]), 32'd6);
        check("serial_fall_cnt", 32'(fall_cnt[0]), 32'd6);
        check("serial_glitch", 32'(glitch_o[0]), 32'h0);

        // Two-cycle pulse on channel 1 is rejected and flagged.
        clear_counts();
        cnt_en = 1'b1;
        dat_i[1] = 1'b1;
        nxt(); nxt();
        dat_i[1] = 1'b0;
        nxt(); nxt();
        check("glitch_pending", 32'(glitch_o[1]), 32'h0);
        nxt();
        check("glitch_set", 32'(glitch_o[1]), 32'h1);
        check("glitch_lvl", 32'(lvl_o[1]), 32'h0);
        clr_i = 1'b1;
        nxt();
        clr_i = 1'b0;
        check("glitch_clr", 32'(glitch_o[1]), 32'h0);
        dat_i[1] = 1'b1;
        nxt(); nxt();
        dat_i[1] = 1'b0;
        nxt(); nxt();
        clr_i = 1'b1;
        nxt();
        clr_i = 1'b0;
        check("glitch_set_wins", 32'(glitch_o[1]), 32'h1);
        repeat (4) nxt();
        cnt_en = 1'b0;
        check("glitch_no_rise", 32'(rise_cnt[1]), 32'h0);
        clr_i = 1'b1;
        nxt();
        clr_i = 1'b0;

        // Mode select: ch0 level, ch1 rise, ch2 fall, ch3 both edges.
        mode_i = 8'b11_10_01_00;
        nxt();
        clear_counts();
        cnt_en = 1'b1;
        dat_i = 4'hF;
        repeat (6) nxt();
        dat_i = 4'h0;
        repeat (12) nxt();
        cnt_en = 1'b0;
        check("mode_level_cycles", 32'(evt_cnt[0]), 32'd6);
        check("mode_rise_cycles", 32'(evt_cnt[1]), 32'd1);
        check("mode_fall_cycles", 32'(evt_cnt[2]), 32'd1);
        check("mode_any_cycles", 32'(evt_cnt[3]), 32'd2);
        mode_i = '0;

        // Reset while channel 2 is mid-filter discards the pending edge.
        clear_counts();
        cnt_en = 1'b1;
        dat_i[2] = 1'b1;
        nxt(); nxt(); nxt();
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        check("midrst_lvl", 32'(lvl_o[2]), 32'h0);
        check("midrst_no_rise", 32'(rise_cnt[2]), 32'h0);
        repeat (4) begin
            nxt();
            check("midrst_lvl_hold", 32'(lvl_o[2]), 32'h0);
        end
        nxt();
        check("midrst_relatch_lvl", 32'(lvl_o[2]), 32'h1);
        check("midrst_relatch_rise", 32'(rise_o[2]), 32'h1);
        cnt_en = 1'b0;
        check("midrst_single_rise", 32'(rise_cnt[2]), 32'h1);

        // Randomised traffic: mixed hold lengths (glitches and clean edges),
        // occasional clears, mode changes and resets.
        for (int c = 0; c < CH; c++) hold[c] = 0;
        repeat (900) begin
            nxt();
            for (int c = 0; c < CH; c++) begin
                if (hold[c] == 0) begin
                    dat_i[c] = ~dat_i[c];
                    hold[c] = int'($urandom_range(1, 9));
                end else begin
                    hold[c]--;
                end
            end
            clr_i = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 99) == 0) mode_i = 8'($urandom);
            rst = ($urandom_range(0, 149) == 0);
        end
        rst = 1'b0;
        clr_i = 1'b0;
        repeat (10) nxt();

        // Deeper chain, no filtering, reset value high.
        rst_b = 1'b1;
        dat_b = 2'b11;
        nxt(); nxt();
        check("b_rst_lvl", 32'(lvl_b), 32'h3);
        check("b_rst_pulses", 32'(rise_b | fall_b), 32'h0);
        rst_b = 1'b0;
        repeat (6) begin
            nxt();
            check("b_exit_lvl", 32'(lvl_b), 32'h3);
            check("b_exit_no_pulse", 32'(rise_b | fall_b), 32'h0);
        end
        dat_b = 2'b00;
        repeat (3) begin
            nxt();
            check("b_latency_hold", 32'(lvl_b), 32'h3);
        end
        nxt();
        check("b_latency_lvl", 32'(lvl_b), 32'h0);
        check("b_latency_fall", 32'(fall_b), 32'h3);
        nxt();
        check("b_fall_1cyc", 32'(fall_b), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
